uart_tx_scheduler: RTL and testbench

//  Shares the UART transmitter (START/DATA_TX/READY_TX/WORK_FR) among N byte-requesters.

---
 rtl/uart_tx_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter among N_REQ byte requesters. Round-robin
//   arbitration, one frame per grant. Sequences the START handshake, watches
//   READY_TX for the frame to begin and end, and owns the WORK_FR word. Config
//   writes are held pending and applied only while idle, so WORK_FR never
//   changes during a frame.
//
// Ports
//   CLK, RESET      clock, synchronous active-high reset
//   REQ, REQ_DATA   per-requester request and byte (byte i at [8i+7:8i])
//   GNT             one-cycle pulse, byte of that requester has been latched
//   CFG_WE          write strobe for CFG_WORK_FR
//   CFG_WORK_FR     new WORK_FR value
//   WORK_FR         to UART.WORK_FR
//   START, DATA_TX  to UART; START is a one-cycle pulse per frame
//   READY_TX        from UART, 1 = transmitter idle
//   BUSY            1 whenever not idle
//   ERR             one-cycle pulse when READY_TX never dropped after START
//   FRAME_CNT       completed frames, wraps
//
// state     | meaning
// S_IDLE    | apply pending config, or arbitrate and grant
// S_LAUNCH  | GNT pulse visible; START is registered for the next cycle
// S_WAIT_ACK| START visible; wait for READY_TX to drop, bounded by ACK_TIMEOUT
// S_WAIT_DONE| frame in progress; wait for READY_TX to return high
module uart_tx_scheduler #(
    parameter int          N_REQ       = 4,
    parameter int          ACK_TIMEOUT = 64,
    parameter logic [11:0] WORK_FR_RST = 12'd434
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] REQ_DATA,
    output logic [N_REQ-1:0]   GNT,
    input  logic               CFG_WE,
    input  logic [11:0]        CFG_WORK_FR,
    output logic [11:0]        WORK_FR,
    output logic               START,
    output logic [7:0]         DATA_TX,
    input  logic               READY_TX,
    output logic               BUSY,
    output logic               ERR,
    output logic [15:0]        FRAME_CNT
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             start_q, start_d;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [11:0]      work_fr_q, work_fr_d;
    logic             cfg_pend_q, cfg_pend_d;
    logic [11:0]      cfg_val_q, cfg_val_d;
    logic [AW-1:0]    ack_cnt_q, ack_cnt_d;

    logic             found;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    cand;
    logic [7:0]       win_data;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = PW'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && REQ[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == PW'(i)) win_data = REQ_DATA[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        start_d     = 1'b0;
        data_d      = data_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        work_fr_d   = work_fr_q;
        cfg_pend_d  = cfg_pend_q;
        cfg_val_d   = cfg_val_q;
        ack_cnt_d   = ack_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_pend_q) begin
                    work_fr_d  = cfg_val_q;
                    cfg_pend_d = 1'b0;
                end else if (!CFG_WE && READY_TX && found) begin
                    // A write arriving this cycle takes precedence; the
                    // grant waits until it has been applied.
                    data_d   = win_data;
                    gnt_d    = N_REQ'(1) << winner;
                    rr_ptr_d = winner;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_d   = 1'b1;
                ack_cnt_d = '0;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!READY_TX) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (READY_TX) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Writes are accepted in any state; the newest value wins.
        if (CFG_WE) begin
            cfg_pend_d = 1'b1;
            cfg_val_d  = CFG_WORK_FR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= PW'(N_REQ - 1);
            gnt_q       <= '0;
            start_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            work_fr_q   <= WORK_FR_RST;
            cfg_pend_q  <= 1'b0;
            cfg_val_q   <= '0;
            ack_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            start_q     <= start_d;
            data_q      <= data_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            work_fr_q   <= work_fr_d;
            cfg_pend_q  <= cfg_pend_d;
            cfg_val_q   <= cfg_val_d;
            ack_cnt_q   <= ack_cnt_d;
        end
    end

    assign GNT       = gnt_q;
    assign START     = start_q;
    assign DATA_TX   = data_q;
    assign ERR       = err_q;
    assign FRAME_CNT = frame_cnt_q;
    assign WORK_FR   = work_fr_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small UART model that drops
// READY_TX when it sees START and raises it again after a few cycles.
module tb_uart_tx_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  REQ;
    logic [31:0] REQ_DATA;
    logic [3:0]  GNT;
    logic        CFG_WE;
    logic [11:0] CFG_WORK_FR;
    logic [11:0] WORK_FR;
    logic        START;
    logic [7:0]  DATA_TX;
    logic        READY_TX;
    logic        BUSY;
    logic        ERR;
    logic [15:0] FRAME_CNT;

    int total = 0;
    int bad   = 0;

    logic model_ready = 1'b1;
    logic ready_low   = 1'b0;
    bit   uart_dead   = 1'b0;
    int   busy_left   = 0;

    assign READY_TX = model_ready & ~ready_low;

    always #5 CLK = ~CLK;

    uart_tx_scheduler #(.N_REQ(4), .ACK_TIMEOUT(64), .WORK_FR_RST(12'd434)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT),
        .CFG_WE(CFG_WE), .CFG_WORK_FR(CFG_WORK_FR), .WORK_FR(WORK_FR),
        .START(START), .DATA_TX(DATA_TX), .READY_TX(READY_TX), .BUSY(BUSY),
        .ERR(ERR), .FRAME_CNT(FRAME_CNT)
    );

    // UART model: frame of about five cycles after START.
    always @(negedge CLK) begin
        if (START && !uart_dead) begin
            model_ready = 1'b0;
            busy_left   = 5;
        end else if (!model_ready) begin
            if (busy_left <= 1) model_ready = 1'b1;
            else busy_left = busy_left - 1;
        end
    end

    task automatic do_reset();
        REQ = '0; REQ_DATA = '0; CFG_WE = 1'b0; CFG_WORK_FR = '0;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic wait_gnt(output logic [3:0] g, output logic [7:0] d, output bit ok);
        ok = 1'b0; g = '0; d = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (GNT != 4'b0) begin
                g = GNT; d = DATA_TX; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!BUSY) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (START) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ = '0; REQ_DATA = '0; CFG_WE = 1'b0; CFG_WORK_FR = '0;
        repeat (2) @(negedge CLK);
        total++;
        if ({GNT, START, DATA_TX, BUSY, ERR, FRAME_CNT, WORK_FR} !==
            {4'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 12'd434}) begin
            bad++;
            $display("FAIL reset_values: gnt=%b start=%b data=%h busy=%b err=%b fc=%h wfr=%0d want 0/0/00/0/0/0000/434",
                     GNT, START, DATA_TX, BUSY, ERR, FRAME_CNT, WORK_FR);
        end
        RESET = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        REQ = 4'b0001; REQ_DATA[7:0] = 8'hA5;
        @(negedge CLK);
        total++;
        if (GNT !== 4'b0001 || DATA_TX !== 8'hA5 || START !== 1'b0) begin
            bad++;
            $display("FAIL single_gnt: gnt=%b data=%h start=%b want 0001 a5 0", GNT, DATA_TX, START);
        end
        REQ = 4'b0000;
        @(negedge CLK);
        total++;
        if (GNT !== 4'b0000 || START !== 1'b1 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL single_start: gnt=%b start=%b busy=%b want 0000 1 1", GNT, START, BUSY);
        end
        @(negedge CLK);
        total++;
        if (START !== 1'b0 || DATA_TX !== 8'hA5) begin
            bad++;
            $display("FAIL single_start_pulse: start=%b data=%h want 0 a5", START, DATA_TX);
        end
        wait_idle(ok);
        total++;
        if (!ok || FRAME_CNT !== 16'd1) begin
            bad++;
            $display("FAIL single_frame_cnt: idle=%0d fc=%0d want 1 1", ok, FRAME_CNT);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g [5];
        logic [7:0]  exp_d [5];
        logic [3:0]  g;
        logic [7:0]  d;
        bit          ok;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        do_reset();
        REQ = 4'b1111; REQ_DATA = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, d, ok);
            total++;
            if (!ok || g !== exp_g[k] || d !== exp_d[k]) begin
                bad++;
                $display("FAIL rr_grant%0d: ok=%0d gnt=%b data=%h want %b %h", k, ok, g, d, exp_g[k], exp_d[k]);
            end
        end
        REQ = 4'b0000;
        wait_idle(ok);
        total++;
        if (!ok || FRAME_CNT !== 16'd5) begin
            bad++;
            $display("FAIL rr_frame_cnt: idle=%0d fc=%0d want 1 5", ok, FRAME_CNT);
        end
    endtask

    task automatic test_skip();
        logic [3:0] g;
        logic [7:0] d;
        bit         ok;
        do_reset();
        REQ = 4'b0100; REQ_DATA = 32'h00C30000;
        wait_gnt(g, d, ok);
        total++;
        if (!ok || g !== 4'b0100 || d !== 8'hC3) begin
            bad++;
            $display("FAIL skip_first: gnt=%b data=%h want 0100 c3", g, d);
        end
        REQ = 4'b1001; REQ_DATA = 32'hD400005A;
        wait_gnt(g, d, ok);
        total++;
        if (!ok || g !== 4'b1000 || d !== 8'hD4) begin
            bad++;
            $display("FAIL skip_to3: gnt=%b data=%h want 1000 d4", g, d);
        end
        REQ = 4'b0001;
        @(negedge CLK);
        REQ_DATA[7:0] = 8'h77;
        wait_gnt(g, d, ok);
        total++;
        if (!ok || g !== 4'b0001 || d !== 8'h77) begin
            bad++;
            $display("FAIL skip_then0: gnt=%b data=%h want 0001 77", g, d);
        end
        REQ = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_ready_low();
        int   early;
        logic [3:0] g;
        logic [7:0] d;
        bit   ok;
        do_reset();
        ready_low = 1'b1;
        REQ = 4'b0001; REQ_DATA = 32'h000000E1;
        early = 0;
        repeat (5) begin
            @(negedge CLK);
            if (GNT !== 4'b0000 || BUSY !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL ready_low_hold: grant/busy seen %0d cycles want 0", early);
        end
        ready_low = 1'b0;
        @(negedge CLK);
        total++;
        if (GNT !== 4'b0001) begin
            bad++;
            $display("FAIL ready_low_release: gnt=%b want 0001", GNT);
        end
        REQ = 4'b0000;
        wait_gnt(g, d, ok);
        wait_idle(ok);
    endtask

    task automatic test_cfg();
        int   changed;
        bit   ok;
        do_reset();
        REQ = 4'b0001; REQ_DATA = 32'h0000003C;
        wait_start(ok);
        REQ = 4'b0010; REQ_DATA = 32'h00005B3C;
        CFG_WE = 1'b1; CFG_WORK_FR = 12'd100;
        @(negedge CLK);
        CFG_WORK_FR = 12'd27;
        @(negedge CLK);
        CFG_WE = 1'b0;
        changed = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (WORK_FR !== 12'd434) changed++;
            if (!BUSY) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        total++;
        if (!ok || changed != 0 || GNT !== 4'b0000) begin
            bad++;
            $display("FAIL cfg_mid_frame: idle=%0d changed=%0d wfr=%0d gnt=%b want 1 0 434 0000", ok, changed, WORK_FR, GNT);
        end
        @(negedge CLK);
        total++;
        if (WORK_FR !== 12'd27 || GNT !== 4'b0000) begin
            bad++;
            $display("FAIL cfg_apply: wfr=%0d gnt=%b want 27 0000", WORK_FR, GNT);
        end
        @(negedge CLK);
        total++;
        if (GNT !== 4'b0010 || DATA_TX !== 8'h5B) begin
            bad++;
            $display("FAIL cfg_then_grant: gnt=%b data=%h want 0010 5b", GNT, DATA_TX);
        end
        REQ = 4'b0000;
        wait_idle(ok);
        total++;
        if (!ok || FRAME_CNT !== 16'd2 || WORK_FR !== 12'd27) begin
            bad++;
            $display("FAIL cfg_after: fc=%0d wfr=%0d want 2 27", FRAME_CNT, WORK_FR);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        do_reset();
        uart_dead = 1'b1;
        REQ = 4'b0001; REQ_DATA = 32'h00000099;
        wait_start(ok);
        REQ = 4'b0000;
        n = 0;
        if (ok) begin
            for (int i = 0; i < 200; i++) begin
                @(negedge CLK);
                n++;
                if (ERR) break;
            end
        end
        total++;
        if (!ok || !ERR || n != 64) begin
            bad++;
            $display("FAIL timeout_len: start=%0d err=%b cycles=%0d want 1 1 64", ok, ERR, n);
        end
        total++;
        if (BUSY !== 1'b0 || FRAME_CNT !== 16'd0) begin
            bad++;
            $display("FAIL timeout_state: busy=%b fc=%0d want 0 0", BUSY, FRAME_CNT);
        end
        @(negedge CLK);
        total++;
        if (ERR !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: err=%b want 0", ERR);
        end
        uart_dead = 1'b0;
    endtask

    task automatic test_reset_and_wrap();
        int   stray;
        bit   ok;
        do_reset();
        CFG_WE = 1'b1; CFG_WORK_FR = 12'd55;
        @(negedge CLK);
        CFG_WE = 1'b0;
        REQ = 4'b0001; REQ_DATA = 32'h00000042;
        wait_start(ok);
        REQ = 4'b0000;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        total++;
        if ({GNT, START, DATA_TX, BUSY, ERR, FRAME_CNT, WORK_FR} !==
            {4'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 12'd434}) begin
            bad++;
            $display("FAIL reset_mid_frame: gnt=%b start=%b data=%h busy=%b err=%b fc=%h wfr=%0d want 0/0/00/0/0/0000/434",
                     GNT, START, DATA_TX, BUSY, ERR, FRAME_CNT, WORK_FR);
        end
        RESET = 1'b0;
        stray = 0;
        repeat (10) begin
            @(negedge CLK);
            if (GNT !== 4'b0000 || START !== 1'b0 || BUSY !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL reset_no_resume: activity in %0d cycles want 0", stray);
        end
        dut.frame_cnt_q = 16'hFFFF;
        REQ = 4'b0001; REQ_DATA = 32'h00000017;
        wait_start(ok);
        REQ = 4'b0000;
        wait_idle(ok);
        total++;
        if (!ok || FRAME_CNT !== 16'h0000) begin
            bad++;
            $display("FAIL frame_cnt_wrap: idle=%0d fc=%h want 1 0000", ok, FRAME_CNT);
        end
    endtask

    initial begin
        RESET = 1'b1; REQ = '0; REQ_DATA = '0; CFG_WE = 1'b0; CFG_WORK_FR = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_skip();
        test_ready_low();
        test_cfg();
        test_timeout();
        test_reset_and_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
